// File: rtl/transducer_hbridge_driver_if.sv
// Signal bundle between the pulse train generator / telemetry side and the H-bridge driver.
// The driver takes the slave modport; the stimulus or upstream logic takes master.
interface transducer_hbridge_driver_if #(
  parameter int CNT_W = 16
) ();
  logic             en;
  logic             pulse_in;
  logic             fault_clr;
  logic             drive_p;
  logic             drive_n;
  logic             active;
  logic             fault;
  logic             burst_done;
  logic [CNT_W-1:0] burst_count;

  modport master (
    output en, pulse_in, fault_clr,
    input  drive_p, drive_n, active, fault, burst_done, burst_count
  );

  modport slave (
    input  en, pulse_in, fault_clr,
    output drive_p, drive_n, active, fault, burst_done, burst_count
  );
endinterface

// File: rtl/transducer_hbridge_driver.sv
// Complementary H-bridge gate driver for the USBL transducer: dead-time insertion,
// end-of-burst detection, stuck-high fault latch and a saturating burst counter.
//
// state     | meaning
// S_IDLE    | bridge off, waiting for the first high half of a burst
// S_DEAD    | both drives off for DEAD_CYCLES before any drive asserts
// S_PHASE_P | drive_p on while pin_q is high
// S_PHASE_N | drive_n on while pin_q is low; a long low ends the burst
// S_FAULT   | input stuck high, bridge off until fault_clr with input low
module transducer_hbridge_driver #(
  parameter int DEAD_CYCLES     = 25,
  parameter int IDLE_CYCLES     = 1500,
  parameter int MAX_HIGH_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input logic                        i_clk,
  input logic                        i_rst_n,
  transducer_hbridge_driver_if.slave hb
);

  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int HIGH_W = (MAX_HIGH_CYCLES > 1) ? $clog2(MAX_HIGH_CYCLES) : 1;

  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [HIGH_W-1:0] HIGH_LAST = HIGH_W'(MAX_HIGH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEAD,
    S_PHASE_P,
    S_PHASE_N,
    S_FAULT
  } state_t;

  state_t           r_state;
  logic             r_pin_q;
  logic [DEAD_W-1:0] r_dead_cnt;
  logic [IDLE_W-1:0] r_low_cnt;
  logic [HIGH_W-1:0] r_high_cnt;
  logic             r_drive_p;
  logic             r_drive_n;
  logic             r_active;
  logic             r_fault;
  logic             r_burst_done;
  logic [CNT_W-1:0] r_burst_count;

  // Outputs default low each cycle and are only re-asserted for the state being
  // entered, so drive_p and drive_n can never overlap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_pin_q       <= 1'b0;
      r_dead_cnt    <= '0;
      r_low_cnt     <= '0;
      r_high_cnt    <= '0;
      r_drive_p     <= 1'b0;
      r_drive_n     <= 1'b0;
      r_active      <= 1'b0;
      r_fault       <= 1'b0;
      r_burst_done  <= 1'b0;
      r_burst_count <= '0;
    end else begin
      r_pin_q      <= hb.pulse_in;
      r_drive_p    <= 1'b0;
      r_drive_n    <= 1'b0;
      r_active     <= 1'b0;
      r_fault      <= 1'b0;
      r_burst_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (hb.en && r_pin_q) begin
            r_state  <= S_DEAD;
            r_active <= 1'b1;
            if (r_burst_count != '1) r_burst_count <= r_burst_count + CNT_W'(1);
          end
        end
        S_DEAD: begin
          if (!hb.en) begin
            r_state    <= S_IDLE;
            r_dead_cnt <= '0;
          end else if (r_dead_cnt == DEAD_LAST) begin
            // Direction comes from the input at expiry, so a short glitch cannot shorten dead-time.
            r_dead_cnt <= '0;
            r_active   <= 1'b1;
            if (r_pin_q) begin
              r_state   <= S_PHASE_P;
              r_drive_p <= 1'b1;
            end else begin
              r_state   <= S_PHASE_N;
              r_drive_n <= 1'b1;
            end
          end else begin
            r_dead_cnt <= r_dead_cnt + DEAD_W'(1);
            r_active   <= 1'b1;
          end
        end
        S_PHASE_P: begin
          if (r_pin_q && (r_high_cnt == HIGH_LAST)) begin
            r_state    <= S_FAULT;
            r_fault    <= 1'b1;
            r_high_cnt <= '0;
          end else if (!hb.en) begin
            r_state    <= S_IDLE;
            r_high_cnt <= '0;
          end else if (!r_pin_q) begin
            r_state    <= S_DEAD;
            r_active   <= 1'b1;
            r_high_cnt <= '0;
          end else begin
            r_high_cnt <= r_high_cnt + HIGH_W'(1);
            r_drive_p  <= 1'b1;
            r_active   <= 1'b1;
          end
        end
        S_PHASE_N: begin
          if (!hb.en) begin
            r_state   <= S_IDLE;
            r_low_cnt <= '0;
          end else if (r_pin_q) begin
            r_state   <= S_DEAD;
            r_active  <= 1'b1;
            r_low_cnt <= '0;
          end else if (r_low_cnt == IDLE_LAST) begin
            r_state      <= S_IDLE;
            r_burst_done <= 1'b1;
            r_low_cnt    <= '0;
          end else begin
            r_low_cnt <= r_low_cnt + IDLE_W'(1);
            r_drive_n <= 1'b1;
            r_active  <= 1'b1;
          end
        end
        S_FAULT: begin
          if (hb.fault_clr && !r_pin_q) r_state <= S_IDLE;
          else                          r_fault <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hb.drive_p     = r_drive_p;
  assign hb.drive_n     = r_drive_n;
  assign hb.active      = r_active;
  assign hb.fault       = r_fault;
  assign hb.burst_done  = r_burst_done;
  assign hb.burst_count = r_burst_count;

endmodule

// File: tb/tb_transducer_hbridge_driver.sv
// Directed and randomized bench for transducer_hbridge_driver; expected drive run
// lengths and counts are derived from half-period lengths and the timing parameters.
module tb_transducer_hbridge_driver;

  localparam int DEAD = 25;
  localparam int IDLE = 1500;
  localparam int MAXH = 1000;
  localparam int TAIL = DEAD + IDLE + 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic pulse_in = 1'b0;
  logic fault_clr = 1'b0;

  always #10 clk = ~clk;

  transducer_hbridge_driver_if #(.CNT_W(16)) b0 ();
  transducer_hbridge_driver_if #(.CNT_W(2))  b1 ();

  assign b0.en = en;
  assign b0.pulse_in = pulse_in;
  assign b0.fault_clr = fault_clr;
  assign b1.en = en;
  assign b1.pulse_in = pulse_in;
  assign b1.fault_clr = fault_clr;

  transducer_hbridge_driver #(.DEAD_CYCLES(DEAD), .IDLE_CYCLES(IDLE), .MAX_HIGH_CYCLES(MAXH), .CNT_W(16))
    u_dut (.i_clk(clk), .i_rst_n(rst_n), .hb(b0.slave));
  transducer_hbridge_driver #(.DEAD_CYCLES(DEAD), .IDLE_CYCLES(IDLE), .MAX_HIGH_CYCLES(MAXH), .CNT_W(2))
    u_dut_sat (.i_clk(clk), .i_rst_n(rst_n), .hb(b1.slave));

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  int p_len = 0, n_len = 0;
  int p_rise = 0, n_rise = 0, p_fall = 0;
  int done_cnt = 0, done_cyc = 0;
  int fault_rises = 0;
  logic fault_prev = 1'b0;
  int q_p[$], q_n[$];
  int exp_p[$], exp_n[$];
  int n_bursts = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; observe 1 ns after the edge and accumulate drive run lengths.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      chk("overlap", {31'd0, b0.drive_p & b0.drive_n}, 32'd0);
      chk("overlap_sat", {31'd0, b1.drive_p & b1.drive_n}, 32'd0);
      if (b0.drive_p) begin
        if (p_len == 0) p_rise = cyc;
        p_len++;
      end else if (p_len != 0) begin
        q_p.push_back(p_len);
        p_len = 0;
        p_fall = cyc;
      end
      if (b0.drive_n) begin
        if (n_len == 0) n_rise = cyc;
        n_len++;
      end else if (n_len != 0) begin
        q_n.push_back(n_len);
        n_len = 0;
      end
      if (b0.burst_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (b0.fault && !fault_prev) fault_rises++;
      fault_prev = b0.fault;
    end
  endtask

  task automatic clear_mon();
    q_p.delete();
    q_n.delete();
    exp_p.delete();
    exp_n.delete();
    p_len = 0;
    n_len = 0;
    done_cnt = 0;
    fault_rises = 0;
  endtask

  task automatic compare_runs(input string tag);
    chk({tag, "_p_runs"}, q_p.size(), exp_p.size());
    foreach (exp_p[i]) if (i < q_p.size()) chk($sformatf("%s_p_len%0d", tag, i), q_p[i], exp_p[i]);
    chk({tag, "_n_runs"}, q_n.size(), exp_n.size());
    foreach (exp_n[i]) if (i < q_n.size()) chk($sformatf("%s_n_len%0d", tag, i), q_n[i], exp_n[i]);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_count"}, {16'd0, b0.burst_count}, n_bursts);
    chk({tag, "_count_sat"}, {30'd0, b1.burst_count}, (n_bursts > 3) ? 3 : n_bursts);
  endtask

  initial begin
    int t0;
    int nper, h, l;

    // Reset values while rst_n is held low
    #25;
    chk("rst_drive_p", b0.drive_p, 0);
    chk("rst_drive_n", b0.drive_n, 0);
    chk("rst_active", b0.active, 0);
    chk("rst_fault", b0.fault, 0);
    chk("rst_done", b0.burst_done, 0);
    chk("rst_count", b0.burst_count, 0);
    chk("rst_count_sat", b1.burst_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(3);

    // Reset asserted in the middle of a drive_p half
    en = 1'b1;
    pulse_in = 1'b1;
    tick(40);
    chk("midrst_drive_p_before", b0.drive_p, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_drive_p_async", b0.drive_p, 0);
    chk("midrst_count", b0.burst_count, 0);
    pulse_in = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    chk("midrst_active_after", b0.active, 0);
    chk("midrst_count_after", b0.burst_count, 0);
    n_bursts = 0;
    clear_mon();

    // Nominal burst: 8 periods of 625 high / 625 low, then idle
    t0 = cyc;
    for (int p = 0; p < 8; p++) begin
      pulse_in = 1'b1;
      exp_p.push_back(625 - DEAD);
      tick(625);
      if (p == 0) chk("nom_latency", p_rise - t0, DEAD + 2);
      pulse_in = 1'b0;
      if (p < 7) begin
        exp_n.push_back(625 - DEAD);
        tick(625);
      end else begin
        exp_n.push_back(IDLE);
        tick(TAIL);
      end
    end
    n_bursts++;
    compare_runs("nom");
    chk("nom_done", done_cnt, 1);
    chk("nom_end_gap", done_cyc - p_fall, DEAD + IDLE);
    chk("nom_active_end", b0.active, 0);
    check_counts("nom");
    clear_mon();

    // Dead-time glitch: 10-cycle high never reaches drive_p
    t0 = cyc;
    pulse_in = 1'b1;
    tick(10);
    pulse_in = 1'b0;
    tick(TAIL);
    n_bursts++;
    exp_n.push_back(IDLE);
    compare_runs("glitch");
    chk("glitch_dead_full", n_rise - t0, DEAD + 2);
    chk("glitch_done", done_cnt, 1);
    check_counts("glitch");
    clear_mon();

    // Stuck-high input latches a fault
    pulse_in = 1'b1;
    tick(1100);
    n_bursts++;
    chk("stuck_fault", b0.fault, 1);
    chk("stuck_drive_p", b0.drive_p, 0);
    chk("stuck_drive_n", b0.drive_n, 0);
    chk("stuck_active", b0.active, 0);
    fault_clr = 1'b1;
    tick(5);
    chk("stuck_clr_while_high", b0.fault, 1);
    pulse_in = 1'b0;
    tick(1);
    chk("stuck_clr_pinq_lag", b0.fault, 1);
    tick(1);
    chk("stuck_clr_release", b0.fault, 0);
    fault_clr = 1'b0;
    tick(10);
    exp_p.push_back(MAXH);
    compare_runs("stuck");
    chk("stuck_done", done_cnt, 0);
    chk("stuck_fault_rises", fault_rises, 1);
    check_counts("stuck");
    clear_mon();

    // en dropped during PHASE_P, then re-enabled with the input still high
    pulse_in = 1'b1;
    tick(40);
    n_bursts++;
    chk("endrop_drive_p_before", b0.drive_p, 1);
    en = 1'b0;
    tick(1);
    chk("endrop_drive_p", b0.drive_p, 0);
    chk("endrop_active", b0.active, 0);
    chk("endrop_done", b0.burst_done, 0);
    tick(5);
    chk("endrop_idle", b0.active, 0);
    check_counts("endrop");
    clear_mon();
    en = 1'b1;
    tick(40);
    n_bursts++;
    chk("reen_drive_p", b0.drive_p, 1);
    check_counts("reen");
    tick(100);
    pulse_in = 1'b0;
    tick(TAIL);
    chk("reen_done", done_cnt, 1);
    clear_mon();

    // Randomized bursts with half-periods that stay clear of both timeouts
    for (int b = 0; b < 3; b++) begin
      nper = $urandom_range(4, 2);
      for (int p = 0; p < nper; p++) begin
        h = $urandom_range(900, DEAD + 5);
        pulse_in = 1'b1;
        exp_p.push_back(h - DEAD);
        tick(h);
        pulse_in = 1'b0;
        if (p < nper - 1) begin
          l = $urandom_range(900, DEAD + 5);
          exp_n.push_back(l - DEAD);
          tick(l);
        end else begin
          exp_n.push_back(IDLE);
          tick(TAIL);
        end
      end
      n_bursts++;
      compare_runs($sformatf("rnd%0d", b));
      chk($sformatf("rnd%0d_done", b), done_cnt, 1);
      check_counts($sformatf("rnd%0d", b));
      clear_mon();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
